// File: rtl/rysy_pkg.sv
// rysy_pkg: shared rysy encodings for next-PC select, fetch states and the NOP instruction
package rysy_pkg;
  typedef enum logic [1:0] {PC_P4, PC_M4, PC_ALU, PC_OLD} pc_sel_e;
  typedef enum logic [1:0] {RESET, FETCH, ISSUE, HALT} fetch_state_e;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
endpackage

// File: rtl/inst_decode_fields.sv
// inst_decode_fields: combinational slicing of an RV32 instruction word (bits [1:0] carry no field)
module inst_decode_fields (
  input  logic [31:2] inst,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);
  assign opcode = inst[6:2];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: rysy fetch stage owning PC and IR; RYSY_MISALIGN_CHECK_EN adds a misaligned-target halt
module inst_fetch
  import rysy_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = NOP_INST_DEF
) (
`ifdef RYSY_MISALIGN_CHECK_EN
  output logic            misaligned,
`endif
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic            next_nop,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_p4,
  output logic [31:0]     inst,
  output logic [4:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            issue,
  output logic            stall
);
  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc_n;
  logic [31:0]     ir, ir_n;
  logic            second, second_n, squash, squash_n, dead, dead_n, hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RESET;
      pc     <= RESET_PC;
      ir     <= NOP_INST;
      second <= 1'b0;
      squash <= 1'b0;
      dead   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir     <= ir_n;
      second <= second_n;
      squash <= squash_n;
      dead   <= dead_n;
    end
  end
  // a squashed (dead) issue always advances by 4, whatever ctrl asks for
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    second_n = second;
    squash_n = squash;
    dead_n   = dead;
    hold     = (pc_sel == PC_OLD || pc_sel == PC_M4) && !second && !dead;
    case (state)
      RESET: state_n = FETCH;
      FETCH: if (imem_valid) begin
        state_n  = ISSUE;
        ir_n     = squash ? NOP_INST : imem_rdata;
        dead_n   = squash;
        squash_n = 1'b0;
        second_n = 1'b0;
      end
      ISSUE: begin
        squash_n = squash | next_nop;
        second_n = hold;
        if (!hold) begin
          state_n = FETCH;
          dead_n  = 1'b0;
          pc_n    = pc + XLEN'(4);
          if (!dead && pc_sel == PC_ALU)
`ifdef RYSY_MISALIGN_CHECK_EN
            if (alu_out[1]) begin
              state_n = HALT;
              pc_n    = pc;
            end else
`endif
            pc_n = alu_out & ~XLEN'(1);
        end
      end
      default: ;
    endcase
  end
  assign imem_req  = state == FETCH;
  assign imem_addr = pc;
  assign pc_p4     = pc + XLEN'(4);
  assign issue     = state == ISSUE;
  assign stall     = state == RESET || state == FETCH;
  assign inst      = issue ? ir : NOP_INST;
`ifdef RYSY_MISALIGN_CHECK_EN
  assign misaligned = state == HALT;
`endif
  inst_decode_fields u_dec (
    .inst   (inst[31:2]),
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed issue/fetch scenario checked every cycle against a transaction-level model
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst, next_nop, imem_req, imem_valid, issue, stall;
  logic [1:0]  pc_sel;
  logic [31:0] alu_out, imem_addr, imem_rdata, pc, pc_p4, inst;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
`ifdef RYSY_MISALIGN_CHECK_EN
  logic        misaligned;
`endif
  always #5 clk = ~clk;
  inst_fetch dut (
`ifdef RYSY_MISALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .alu_out    (alu_out),
    .next_nop   (next_nop),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc         (pc),
    .pc_p4      (pc_p4),
    .inst       (inst),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .issue      (issue),
    .stall      (stall)
  );
  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[23:0], 8'h33};
  endfunction
  // per issued instruction: action driven that cycle plus the hand-computed pc/inst it must show
  int          t_sel  [13] = '{0, 0, 3, 3, 2, 2, 0, 1, 1, 0, 2, 0, 0};
  logic [31:0] t_alu  [13] = '{0, 0, 0, 0, 32'h101, 32'h40, 0, 0, 0, 0, 32'hFFFF_FFFD, 0, 0};
  logic        t_nop  [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] t_pc   [13] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h100, 32'h40, 32'h44, 32'h44,
                               32'h48, 32'h0, 32'hFFFF_FFFC, 32'h0};
  logic [31:0] t_inst [13] = '{32'h33, 32'h433, 32'h833, 32'h833, 32'hC33, 32'h1_0033, NOP, 32'h4433,
                               32'h4433, 32'h4833, 32'h33, 32'hFFFF_FC33, 32'h33};
  // per fetch: response latency in cycles after the request appears, and the address it must use
  int          f_lat  [13] = '{0, 3, 0, 0, 2, 0, 1, 1, 99, 0, 0, 0, 0};
  logic [31:0] f_addr [13] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h40, 32'h44, 32'h48, 32'h4C,
                               32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
  int          ph, k, f, wcnt;
  logic [31:0] mpc, mir, ei;
  logic        kill, killed, held, late, done;
  initial begin
    rst = 1'b1; pc_sel = 2'd0; alu_out = '0; next_nop = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    ph = 0; mpc = 32'h0; mir = NOP; kill = 0; killed = 0; held = 0; late = 0; done = 0;
    k = 0; f = 0; wcnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_inst", inst, NOP);
    chk("reset_req", imem_req, 1'b0);
    chk("reset_issue", issue, 1'b0);
    chk("reset_stall", stall, 1'b1);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      ei = (ph == 2) ? mir : NOP;
      chk("pc", pc, mpc);
      chk("pc_p4", pc_p4, mpc + 32'd4);
      chk("imem_req", imem_req, ph == 1);
      chk("issue", issue, ph == 2);
      chk("stall", stall, ph != 2);
      chk("inst", inst, ei);
      chk("opcode", opcode, ei[6:2]);
      chk("func3", func3, ei[14:12]);
      chk("func7", func7, ei[31:25]);
      chk("rd", rd, ei[11:7]);
      chk("rs1", rs1, ei[19:15]);
      chk("rs2", rs2, ei[24:20]);
      if (ph == 1) chk("imem_addr", imem_addr, mpc);
      rst = 1'b0; pc_sel = 2'd0; alu_out = $urandom; next_nop = 1'b0;
      imem_valid = 1'b0; imem_rdata = $urandom;
      if (late) begin
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        late = 0;
      end else if (ph == 1) begin
        if (wcnt == 0) chk("fetch_addr_lit", imem_addr, f_addr[f]);
        if (f == 8 && wcnt == 2) begin
          rst = 1'b1;
          late = 1;
        end else if (wcnt == f_lat[f]) begin
          imem_valid = 1'b1;
          imem_rdata = mem(mpc);
        end
      end else if (ph == 2) begin
        if (k == 13) begin
          done = 1;
          break;
        end
        chk("issue_pc_lit", pc, t_pc[k]);
        chk("issue_inst_lit", inst, t_inst[k]);
        pc_sel = 2'(t_sel[k]);
        alu_out = t_alu[k];
        next_nop = t_nop[k];
      end
      @(posedge clk);
      if (rst) begin
        if (ph == 1) f++;
        ph = 0; mpc = 32'h0; mir = NOP; kill = 0; killed = 0; held = 0; wcnt = 0;
      end else if (ph == 0) begin
        ph = 1;
        wcnt = 0;
      end else if (ph == 1) begin
        if (imem_valid) begin
          mir = kill ? NOP : imem_rdata;
          killed = kill;
          kill = 0;
          held = 0;
          ph = 2;
          f++;
        end else wcnt++;
      end else begin
        k++;
        kill = kill | next_nop;
        if (!killed && !held && (pc_sel == 2'd3 || pc_sel == 2'd1)) held = 1;
        else begin
          held = 0;
          mpc = (!killed && pc_sel == 2'd2) ? {alu_out[31:1], 1'b0} : mpc + 32'd4;
          killed = 0;
          ph = 1;
          wcnt = 0;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL timeout: got %0d issues, expected 13", k);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
